// File: rtl/picorv32_axil_pkg.sv
// Shared definitions for the picorv32 AXI4-Lite initiator.
//   state_t      : transaction FSM states
//   RESP_*       : AXI response codes the initiator distinguishes
//   PROT_*       : AxPROT encodings for instruction fetches and data accesses
package picorv32_axil_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] PROT_INSN = 3'b100;
    localparam logic [2:0] PROT_DATA = 3'b000;

endpackage

// File: rtl/picorv32_axil_initiator.sv
// AXI4-Lite initiator for the picorv32 native memory interface.
// One transaction in flight; AW and W handshakes are tracked independently.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   mem_valid/instr/addr/wdata/wstrb   native request (wstrb==0 means read)
//   mem_ready, mem_rdata, mem_err      one-cycle completion, read data, error flag
//   timeout                    sticky watchdog flag, cleared only by reset
//   m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*   AXI4-Lite manager channels
module picorv32_axil_initiator
    import picorv32_axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        timeout,

    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,

    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,

    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,

    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,

    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp
);

    localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q, wd_cnt;
    logic [3:0]  wstrb_q;
    logic [1:0]  resp_q;
    logic        instr_q, aw_done, w_done;
    logic        accept, aw_hs, w_hs;

    // Every valid/ready is decoded from registered state, so reset drops
    // them immediately and they cannot glitch.
    assign accept        = (state_q == IDLE) && mem_valid;
    assign m_axi_arvalid = (state_q == RD_ADDR);
    assign m_axi_rready  = (state_q == RD_DATA);
    assign m_axi_awvalid = (state_q == WR_REQ) && !aw_done;
    assign m_axi_wvalid  = (state_q == WR_REQ) && !w_done;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign mem_ready     = (state_q == DONE);
    assign mem_err       = (state_q == DONE) && (resp_q != RESP_OKAY);
    assign mem_rdata     = rdata_q;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = instr_q ? PROT_INSN : PROT_DATA;
    assign m_axi_arprot = instr_q ? PROT_INSN : PROT_DATA;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_valid) state_d = (mem_wstrb == 4'b0000) ? RD_ADDR : WR_REQ;
            RD_ADDR: if (m_axi_arready) state_d = RD_DATA;
            RD_DATA: if (m_axi_rvalid) state_d = DONE;
            // Either handshake may complete first, or both on the same edge.
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_d = WR_RESP;
            WR_RESP: if (m_axi_bvalid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                instr_q <= mem_instr;
                rdata_q <= '0;           // writes report zero read data
                resp_q  <= RESP_OKAY;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (m_axi_rvalid && m_axi_rready) begin
                rdata_q <= m_axi_rdata;
                resp_q  <= m_axi_rresp;
            end
            if (m_axi_bvalid && m_axi_bready) resp_q <= m_axi_bresp;
        end
    end

    // Watchdog only flags; aborting would leave the subordinate mid-handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (accept)
                wd_cnt <= '0;
            else if (state_q != IDLE && wd_cnt != TO)
                wd_cnt <= wd_cnt + 32'd1;
            if (TO != 32'd0 && state_q != IDLE && wd_cnt == TO - 32'd1)
                timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_picorv32_axil_initiator.sv
// Directed self-checking bench for picorv32_axil_initiator (TIMEOUT_CYCLES=8).
// The bench plays the AXI subordinate cycle by cycle; inputs change 1ns
// after each rising edge and outputs are sampled at the same point.
module tb_picorv32_axil_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_err, timeout;
    logic [31:0] mem_rdata;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;

    int checks = 0;
    int failures = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    picorv32_axil_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .timeout(timeout),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    always #5 clk = ~clk;

    // Handshake counters, sampled on the edge where the handshake happens.
    always @(posedge clk) begin
        if (!reset) begin
            if (m_axi_awvalid && m_axi_awready) aw_cnt++;
            if (m_axi_wvalid && m_axi_wready)   w_cnt++;
            if (m_axi_bvalid && m_axi_bready)   b_cnt++;
            if (m_axi_arvalid && m_axi_arready) ar_cnt++;
            if (m_axi_rvalid && m_axi_rready)   r_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_valid = 0; mem_instr = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
        tick(); tick();
        checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
            failures++; $display("FAIL reset_valids got=%b exp=00000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}); end
        checks++; if ({mem_ready, mem_err, timeout} !== 3'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {mem_ready, mem_err, timeout}); end
        checks++; if (mem_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got=%h exp=00000000", mem_rdata); end
        reset = 1'b0;
        tick();
    endtask

    // T1: zero-wait read; also checks a still-held mem_valid is ignored in DONE.
    task automatic test_read();
        int ar0;
        ar0 = ar_cnt;
        mem_valid = 1; mem_instr = 0; mem_addr = 32'h100; mem_wstrb = 4'b0; m_axi_arready = 1;
        tick();  // accept edge
        checks++; if (m_axi_arvalid !== 1'b1 || m_axi_awvalid !== 1'b0) begin
            failures++; $display("FAIL t1_arvalid got=%b/%b exp=1/0", m_axi_arvalid, m_axi_awvalid); end
        checks++; if (m_axi_araddr !== 32'h100 || m_axi_arprot !== 3'b000) begin
            failures++; $display("FAIL t1_araddr got=%h/%b exp=00000100/000", m_axi_araddr, m_axi_arprot); end
        tick();  // AR handshake
        m_axi_rvalid = 1; m_axi_rdata = 32'hDEADBEEF; m_axi_rresp = 2'b00;
        checks++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b1 || mem_ready !== 1'b0) begin
            failures++; $display("FAIL t1_rd_data got=%b%b%b exp=010", m_axi_arvalid, m_axi_rready, mem_ready); end
        tick();  // R handshake, third edge from accept
        m_axi_rvalid = 0; m_axi_arready = 0;
        checks++; if (mem_ready !== 1'b1 || mem_err !== 1'b0) begin
            failures++; $display("FAIL t1_ready got=%b%b exp=10", mem_ready, mem_err); end
        checks++; if (mem_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL t1_rdata got=%h exp=deadbeef", mem_rdata); end
        tick();  // DONE -> IDLE with mem_valid still high
        checks++; if (mem_ready !== 1'b0 || m_axi_arvalid !== 1'b0) begin
            failures++; $display("FAIL t1_no_reaccept got=%b%b exp=00", mem_ready, m_axi_arvalid); end
        mem_valid = 0;
        tick();
        checks++; if (ar_cnt - ar0 !== 1) begin
            failures++; $display("FAIL t1_ar_count got=%0d exp=1", ar_cnt - ar0); end
    endtask

    // T2: write, W accepted two cycles before AW.
    task automatic test_write_w_first();
        int aw0, w0, b0;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        mem_valid = 1; mem_addr = 32'h200; mem_wdata = 32'h12345678; mem_wstrb = 4'b0011;
        tick();
        checks++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1 || m_axi_bready !== 1'b0) begin
            failures++; $display("FAIL t2_valids got=%b%b%b exp=110", m_axi_awvalid, m_axi_wvalid, m_axi_bready); end
        checks++; if (m_axi_awaddr !== 32'h200 || m_axi_wdata !== 32'h12345678 || m_axi_wstrb !== 4'b0011 || m_axi_awprot !== 3'b000) begin
            failures++; $display("FAIL t2_payload got=%h %h %b %b exp=00000200 12345678 0011 000",
                m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_awprot); end
        m_axi_wready = 1;
        tick();  // W handshake
        m_axi_wready = 0;
        checks++; if (m_axi_wvalid !== 1'b0 || m_axi_awvalid !== 1'b1 || m_axi_bready !== 1'b0) begin
            failures++; $display("FAIL t2_after_w got=%b%b%b exp=010", m_axi_wvalid, m_axi_awvalid, m_axi_bready); end
        tick();
        checks++; if (m_axi_awvalid !== 1'b1 || m_axi_bready !== 1'b0 || m_axi_awaddr !== 32'h200) begin
            failures++; $display("FAIL t2_aw_held got=%b%b %h exp=10 00000200", m_axi_awvalid, m_axi_bready, m_axi_awaddr); end
        m_axi_awready = 1;
        tick();  // AW handshake
        m_axi_awready = 0;
        checks++; if (m_axi_awvalid !== 1'b0 || m_axi_bready !== 1'b1) begin
            failures++; $display("FAIL t2_wr_resp got=%b%b exp=01", m_axi_awvalid, m_axi_bready); end
        m_axi_bvalid = 1; m_axi_bresp = 2'b00;
        tick();  // B handshake
        m_axi_bvalid = 0;
        checks++; if (mem_ready !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 32'h0 || m_axi_bready !== 1'b0) begin
            failures++; $display("FAIL t2_done got=%b%b %h %b exp=10 00000000 0", mem_ready, mem_err, mem_rdata, m_axi_bready); end
        mem_valid = 0;
        tick();
        checks++; if (aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1 || b_cnt - b0 !== 1) begin
            failures++; $display("FAIL t2_counts got=%0d/%0d/%0d exp=1/1/1", aw_cnt - aw0, w_cnt - w0, b_cnt - b0); end
    endtask

    // T3: instruction fetch answered with SLVERR, then a normal read.
    task automatic test_fetch_slverr();
        mem_valid = 1; mem_instr = 1; mem_addr = 32'h300; mem_wstrb = 4'b0; m_axi_arready = 1;
        tick();
        checks++; if (m_axi_arprot !== 3'b100 || m_axi_araddr !== 32'h300) begin
            failures++; $display("FAIL t3_arprot got=%b %h exp=100 00000300", m_axi_arprot, m_axi_araddr); end
        tick();
        m_axi_rvalid = 1; m_axi_rdata = 32'hCAFEF00D; m_axi_rresp = 2'b10;
        tick();
        m_axi_rvalid = 0; mem_valid = 0; mem_instr = 0;
        checks++; if (mem_ready !== 1'b1 || mem_err !== 1'b1 || mem_rdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL t3_err got=%b%b %h exp=11 cafef00d", mem_ready, mem_err, mem_rdata); end
        tick();
        checks++; if (mem_err !== 1'b0 || mem_ready !== 1'b0) begin
            failures++; $display("FAIL t3_err_pulse got=%b%b exp=00", mem_ready, mem_err); end
        mem_valid = 1; mem_addr = 32'h104;
        tick();
        checks++; if (m_axi_arvalid !== 1'b1 || m_axi_arprot !== 3'b000 || m_axi_araddr !== 32'h104) begin
            failures++; $display("FAIL t3_next got=%b %b %h exp=1 000 00000104", m_axi_arvalid, m_axi_arprot, m_axi_araddr); end
        tick();
        m_axi_rvalid = 1; m_axi_rdata = 32'h00000011; m_axi_rresp = 2'b00;
        tick();
        m_axi_rvalid = 0; mem_valid = 0; m_axi_arready = 0;
        checks++; if (mem_ready !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 32'h11) begin
            failures++; $display("FAIL t3_next_done got=%b%b %h exp=10 00000011", mem_ready, mem_err, mem_rdata); end
        tick();
    endtask

    // T4: bvalid high from awvalid rise, awready delayed three cycles.
    task automatic test_early_bvalid();
        int aw0, w0, b0;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        mem_valid = 1; mem_addr = 32'h400; mem_wdata = 32'hA5A5A5A5; mem_wstrb = 4'hF; m_axi_wready = 1;
        tick();  // accept
        m_axi_bvalid = 1; m_axi_bresp = 2'b00;
        tick();  // W handshake
        m_axi_wready = 0;
        checks++; if (m_axi_bready !== 1'b0 || m_axi_awvalid !== 1'b1) begin
            failures++; $display("FAIL t4_bready_c1 got=%b%b exp=01", m_axi_bready, m_axi_awvalid); end
        tick();
        tick();
        checks++; if (m_axi_bready !== 1'b0 || mem_ready !== 1'b0) begin
            failures++; $display("FAIL t4_bready_c3 got=%b%b exp=00", m_axi_bready, mem_ready); end
        m_axi_awready = 1;
        tick();  // AW handshake
        m_axi_awready = 0;
        checks++; if (m_axi_bready !== 1'b1 || b_cnt - b0 !== 0) begin
            failures++; $display("FAIL t4_wr_resp got=%b %0d exp=1 0", m_axi_bready, b_cnt - b0); end
        tick();  // B handshake
        m_axi_bvalid = 0; mem_valid = 0;
        checks++; if (mem_ready !== 1'b1 || mem_err !== 1'b0) begin
            failures++; $display("FAIL t4_done got=%b%b exp=10", mem_ready, mem_err); end
        tick();
        checks++; if (aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1 || b_cnt - b0 !== 1) begin
            failures++; $display("FAIL t4_counts got=%0d/%0d/%0d exp=1/1/1", aw_cnt - aw0, w_cnt - w0, b_cnt - b0); end
    endtask

    // T5: arready never comes; watchdog flags after 8 cycles without aborting.
    task automatic test_watchdog();
        mem_valid = 1; mem_addr = 32'h500; mem_wstrb = 4'b0; m_axi_arready = 0;
        tick();  // accept
        for (int i = 0; i < 7; i++) tick();
        checks++; if (timeout !== 1'b0) begin
            failures++; $display("FAIL t5_early got=%b exp=0", timeout); end
        tick();
        checks++; if (timeout !== 1'b1 || m_axi_arvalid !== 1'b1) begin
            failures++; $display("FAIL t5_fire got=%b%b exp=11", timeout, m_axi_arvalid); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (timeout !== 1'b1 || m_axi_arvalid !== 1'b1 || mem_ready !== 1'b0) begin
            failures++; $display("FAIL t5_sticky got=%b%b%b exp=110", timeout, m_axi_arvalid, mem_ready); end
        mem_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        checks++; if (timeout !== 1'b0 || m_axi_arvalid !== 1'b0) begin
            failures++; $display("FAIL t5_cleared got=%b%b exp=00", timeout, m_axi_arvalid); end
        tick();
    endtask

    // T6: asynchronous reset in the middle of a write.
    task automatic test_reset_mid_write();
        int b0;
        mem_valid = 1; mem_addr = 32'h600; mem_wdata = 32'h0BADF00D; mem_wstrb = 4'hF;
        m_axi_awready = 0; m_axi_wready = 0;
        tick();
        checks++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin
            failures++; $display("FAIL t6_pre got=%b%b exp=11", m_axi_awvalid, m_axi_wvalid); end
        #2 reset = 1;
        #1;
        checks++; if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || mem_ready !== 1'b0) begin
            failures++; $display("FAIL t6_async got=%b%b%b exp=000", m_axi_awvalid, m_axi_wvalid, mem_ready); end
        tick(); tick();
        checks++; if (mem_ready !== 1'b0 || m_axi_awvalid !== 1'b0) begin
            failures++; $display("FAIL t6_held got=%b%b exp=00", mem_ready, m_axi_awvalid); end
        reset = 0;
        tick();  // first edge after release accepts the held request
        checks++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1 || m_axi_awaddr !== 32'h600) begin
            failures++; $display("FAIL t6_accept got=%b%b %h exp=11 00000600", m_axi_awvalid, m_axi_wvalid, m_axi_awaddr); end
        b0 = b_cnt;
        m_axi_awready = 1; m_axi_wready = 1;
        tick();  // both handshakes on the same edge
        m_axi_awready = 0; m_axi_wready = 0;
        checks++; if (m_axi_bready !== 1'b1) begin
            failures++; $display("FAIL t6_wr_resp got=%b exp=1", m_axi_bready); end
        m_axi_bvalid = 1; m_axi_bresp = 2'b10;
        tick();
        m_axi_bvalid = 0; mem_valid = 0;
        checks++; if (mem_ready !== 1'b1 || mem_err !== 1'b1 || b_cnt - b0 !== 1) begin
            failures++; $display("FAIL t6_done got=%b%b %0d exp=11 1", mem_ready, mem_err, b_cnt - b0); end
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_w_first();
        test_fetch_slverr();
        test_early_bvalid();
        test_watchdog();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit reached exp=finish earlier");
        $fatal(1, "time limit");
    end

endmodule
